// File: rtl/dense_pkg.sv
// Shared defaults and state encoding for the dense-layer sequencer and its MAC datapath.
package dense_pkg;

   localparam int N_FEAT_DEF    = 40;
   localparam int N_NEUR_DEF    = 8;
   localparam int FRAC_BITS_DEF = 15;
   localparam int BIAS_BASE_DEF = N_FEAT_DEF * N_NEUR_DEF;

   typedef enum logic [2:0] {
      LOAD,
      BIAS,
      MAC,
      FIN,
      EMIT
   } state_t;

endpackage

// File: rtl/dense_layer_sequencer_mac_unit.sv
// Combinational Q-format multiply-accumulate step: signed product, arithmetic
// shift, truncation to 16 bits, and a wrapping 16-bit add into the accumulator.
module mac_unit #(
   parameter int FRAC_BITS = 15
) (
   input  logic signed [15:0] feat,
   input  logic signed [15:0] weight,
   input  logic signed [15:0] acc_in,
   output logic signed [15:0] acc_out
);

   logic signed [31:0] product;
   logic signed [15:0] term;

   always_comb begin
      product = feat * weight;
      term    = 16'(product >>> FRAC_BITS);
      acc_out = acc_in + term;
   end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Buffers one MFCC frame, then walks every neuron through bias fetch, MAC over
// all features and result emission, tracking the argmax across the frame.
module dense_layer_sequencer
   import dense_pkg::*;
#(
   parameter int N_FEAT    = N_FEAT_DEF,
   parameter int N_NEUR    = N_NEUR_DEF,
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int BIAS_BASE = BIAS_BASE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in_data,
   output logic               w_en,
   output logic [8:0]         w_addr,
   input  logic signed [15:0] w_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_data,
   output logic [2:0]         out_index,
   output logic               out_last,
   output logic [2:0]         out_class,
   output logic               busy
);

   localparam int CW = $clog2(N_FEAT);

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] j_q, j_d;
   logic [2:0] n_q, n_d;
   logic signed [15:0] acc_q, acc_d;
   logic signed [15:0] max_q, max_d;
   logic [2:0] max_idx_q, max_idx_d;

   logic signed [15:0] feat_q [N_FEAT];

   logic in_fire, out_fire;
   logic last_feat, last_j, last_n;
   logic new_max;
   logic [CW-1:0] term_idx;
   logic signed [15:0] term_feat;
   logic signed [15:0] mac_sum;

   always_comb begin
      in_fire   = (state_q == LOAD) && in_valid;
      out_fire  = (state_q == EMIT) && out_ready;
      last_feat = cnt_q == CW'(N_FEAT - 1);
      last_j    = j_q == CW'(N_FEAT - 1);
      last_n    = n_q == 3'(N_NEUR - 1);
      new_max   = (n_q == 3'd0) || (acc_q > max_q);
      // MAC step j folds in the weight fetched for feature j-1; FIN folds in the last one.
      term_idx  = (state_q == FIN) ? CW'(N_FEAT - 1) : j_q - CW'(1);
      term_feat = feat_q[term_idx];
   end

   mac_unit #(
      .FRAC_BITS (FRAC_BITS)
   ) u_mac (
      .feat    (term_feat),
      .weight  (w_data),
      .acc_in  (acc_q),
      .acc_out (mac_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOAD;
         cnt_q     <= '0;
         j_q       <= '0;
         n_q       <= '0;
         acc_q     <= '0;
         max_q     <= '0;
         max_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         j_q       <= j_d;
         n_q       <= n_d;
         acc_q     <= acc_d;
         max_q     <= max_d;
         max_idx_q <= max_idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         feat_q[cnt_q] <= in_data;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (in_fire && last_feat) state_d = BIAS;
         BIAS:    state_d = MAC;
         MAC:     if (last_j) state_d = FIN;
         FIN:     state_d = EMIT;
         EMIT:    if (out_fire) state_d = last_n ? LOAD : BIAS;
         default: state_d = LOAD;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      j_d       = j_q;
      n_d       = n_q;
      acc_d     = acc_q;
      max_d     = max_q;
      max_idx_d = max_idx_q;
      case (state_q)
         LOAD: begin
            if (in_fire) begin
               cnt_d = last_feat ? '0 : cnt_q + CW'(1);
               if (last_feat) n_d = '0;
            end
         end
         BIAS: j_d = '0;
         MAC: begin
            acc_d = (j_q == '0) ? w_data : mac_sum;
            j_d   = last_j ? '0 : j_q + CW'(1);
         end
         FIN: acc_d = mac_sum;
         EMIT: begin
            if (out_fire) begin
               if (new_max) begin
                  max_d     = acc_q;
                  max_idx_d = n_q;
               end
               n_d   = last_n ? '0 : n_q + 3'd1;
               cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      w_en      = 1'b0;
      w_addr    = '0;
      out_valid = 1'b0;
      out_data  = '0;
      out_index = '0;
      out_last  = 1'b0;
      out_class = '0;
      busy      = state_q != LOAD;
      case (state_q)
         LOAD: in_ready = 1'b1;
         BIAS: begin
            w_en   = 1'b1;
            w_addr = 9'(BIAS_BASE + int'(n_q));
         end
         MAC: begin
            w_en   = 1'b1;
            w_addr = 9'(int'(n_q) * N_FEAT + int'(j_q));
         end
         EMIT: begin
            out_valid = 1'b1;
            out_data  = acc_q;
            out_index = n_q;
            out_last  = last_n;
            // The last neuron competes with the running max before it is registered.
            if (last_n) out_class = new_max ? n_q : max_idx_q;
         end
         default: ;
      endcase
   end

endmodule
